serial_frame_receiver: RTL and testbench
========================================

// Module: serial_frame_receiver
// PURPOSE
//  Receive end of the 133-byte game-state frame: start, 3 data bytes, 64 obstacle bytes,
//  64 objective bytes, end. Consumes bytes from a UART RX, fills shadow registers, and
//  commits them atomically to the outputs only when the frame's end byte is correct.
//  Sits between the UART receiver and the consumer of the map and game data.
// PARAMETERS
//  START_BYTE      8'hFF   frame start marker
//  END_BYTE        8'hFE   frame end marker
//  MAP_BYTES       64      bytes per map section; map width = MAP_BYTES*8
//  TIMEOUT_CYCLES  50000   idle cycles allowed between bytes mid-frame (FRAME_TIMEOUT_EN only)
// PORTS
//  clock           in   1      system clock, rising edge
//  reset_n         in   1      asynchronous, active-low reset
//  rx_data         in   8      received byte
//  rx_valid        in   1      1-cycle strobe: rx_data valid
//  D0, D1, D2      out  8      committed data bytes 0..2
//  map_obstacles   out  512    committed obstacle map
//  map_objectives  out  512    committed objective map
//  frame_valid     out  1      1-cycle pulse: new frame committed
//  frame_error     out  1      1-cycle pulse: frame aborted
//  busy            out  1      high while a frame is in progress (any state except IDLE)
//  db_state        out  3      FSM state, for debug
// BEHAVIOUR
//  - Reset: all outputs, shadow registers, and counters go to 0; state goes to IDLE.
//    A reset mid-frame discards the partial frame and raises no pulse.
//  - FSM states (db_state encoding): IDLE=0, HEADER=1, OBST=2, OBJ=3, TAIL=4.
//    Transitions happen only on rx_valid, except the timeout abort.
//  - IDLE: if rx_data==START_BYTE, go to HEADER and clear byte counter cnt.
//    Any other byte is discarded silently (resync).
//  - HEADER: byte i (i=0..2) goes to shadow Di. After i==2, go to OBST with cnt=0.
//  - OBST: byte k goes to shadow_obs[8k+7:8k]; first byte received is the LSB.
//    After k==MAP_BYTES-1, go to OBJ with cnt=0.
//  - OBJ: same fill rule into shadow_obj. After k==MAP_BYTES-1, go to TAIL.
//  - TAIL, byte==END_BYTE: on the next edge, copy all shadow registers to the outputs
//    and pulse frame_valid for 1 cycle; go to IDLE.
//  - TAIL, any other byte: pulse frame_error for 1 cycle; outputs keep their previous
//    frame; go to IDLE.
//  - Framing is purely positional. START_BYTE or END_BYTE values inside the payload
//    are stored as data; there is no byte stuffing.
//  - Latency: outputs and frame_valid are registered and change in the cycle after the
//    edge that sampled the end byte. They are never partially updated.
//  - Back-to-back frames: a start byte may arrive on the very next rx_valid after the
//    end byte and must be accepted.
//  - rx_valid held high for several cycles counts as one byte per cycle.
//  - cnt is 6 bits for the default MAP_BYTES=64; it wraps at the section end by reload.
//  - frame_valid and frame_error are never high in the same cycle.
// CONFIGURATION
//  FRAME_TIMEOUT_EN defined:
//    - A counter clears on every rx_valid and runs while busy.
//    - When it reaches TIMEOUT_CYCLES with no rx_valid, pulse frame_error, go to IDLE,
//      and leave the outputs unchanged.
//    - In IDLE the counter holds at 0.
//  FRAME_TIMEOUT_EN undefined:
//    - No counter logic exists; the FSM waits indefinitely mid-frame.
// TESTING
//  1. Frame FF,01,02,03, obs bytes 00..3F, obj bytes 80..BF, FE ->
//     frame_valid 1 cycle; D0=01, D1=02, D2=03; map_obstacles[7:0]=00, [511:504]=3F;
//     map_objectives[7:0]=80, [511:504]=BF.
//  2. Good frame, then a frame whose tail byte is 0x00 -> frame_error 1 cycle;
//     outputs still hold frame 1; next valid frame commits normally.
//  3. Garbage 12,34 before FF, payload all FF, then FE -> garbage ignored;
//     D0=FF; maps all-ones; frame_valid.
//  4. reset_n low after byte 70 of a frame, then a full frame -> outputs 0 during reset;
//     only the second frame commits; no error pulse.
//  5. Two frames with zero gap and rx_valid on consecutive cycles ->
//     two frame_valid pulses; second data wins.
//  6. FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: stop after byte 10 ->
//     frame_error at idle cycle 100; busy=0; outputs unchanged.

Source files
------------

// File: rtl/serial_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver_if
//   Groups the byte stream from the UART receiver with the committed
//   game-state outputs of serial_frame_receiver.
//   master : byte source / data consumer (drives rx_*, observes results)
//   slave  : serial_frame_receiver (consumes rx_*, drives results)
//   Signals:
//     rx_data[7:0], rx_valid            received byte + 1-cycle strobe
//     D0, D1, D2 [7:0]                  committed data bytes
//     map_obstacles, map_objectives     committed maps, MAP_BYTES*8 bits each
//     frame_valid, frame_error          1-cycle commit / abort pulses
//     busy, db_state[2:0]               frame in progress, FSM state
// ---------------------------------------------------------------------------
interface serial_frame_receiver_if #(
  parameter int unsigned MAP_BYTES = 64
);
  localparam int unsigned MAP_W = MAP_BYTES * 8;

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic [7:0]       D0;
  logic [7:0]       D1;
  logic [7:0]       D2;
  logic [MAP_W-1:0] map_obstacles;
  logic [MAP_W-1:0] map_objectives;
  logic             frame_valid;
  logic             frame_error;
  logic             busy;
  logic [2:0]       db_state;

  modport master (
    output rx_data, rx_valid,
    input  D0, D1, D2, map_obstacles, map_objectives,
    input  frame_valid, frame_error, busy, db_state
  );

  modport slave (
    input  rx_data, rx_valid,
    output D0, D1, D2, map_obstacles, map_objectives,
    output frame_valid, frame_error, busy, db_state
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// serial_frame_receiver
//   Receives the positional game-state frame
//     START, D0, D1, D2, MAP_BYTES obstacle bytes, MAP_BYTES objective bytes, END
//   from a UART byte stream into shadow registers and commits all of them to
//   the outputs in one cycle only when the trailing byte equals END_BYTE.
//   Ports:
//     clock    rising-edge system clock
//     reset_n  asynchronous active-low reset (discards any partial frame)
//     bus      serial_frame_receiver_if.slave (byte input, committed outputs)
//   Optional feature (macro FRAME_TIMEOUT_EN): abort a frame after
//   TIMEOUT_CYCLES consecutive cycles without rx_valid while busy.
// ---------------------------------------------------------------------------
module serial_frame_receiver #(
  parameter logic [7:0]  START_BYTE = 8'hFF,
  parameter logic [7:0]  END_BYTE   = 8'hFE,
  parameter int unsigned MAP_BYTES  = 64
`ifdef FRAME_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
  input  logic                    clock,
  input  logic                    reset_n,
  serial_frame_receiver_if.slave  bus
);

  localparam int unsigned MAP_W = MAP_BYTES * 8;
  // Counter must reach both the last header index (2) and MAP_BYTES-1.
  localparam int unsigned CNT_W = (MAP_BYTES > 4) ? $clog2(MAP_BYTES) : 2;
  localparam int unsigned IDX_W = CNT_W + 3;
  localparam logic [CNT_W-1:0] LAST_HDR = CNT_W'(2);
  localparam logic [CNT_W-1:0] LAST_MAP = CNT_W'(MAP_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_OBST   = 3'd2,
    ST_OBJ    = 3'd3,
    ST_TAIL   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Shadow registers filled while the frame streams in
  logic [7:0]       shd0_q, shd0_d;
  logic [7:0]       shd1_q, shd1_d;
  logic [7:0]       shd2_q, shd2_d;
  logic [MAP_W-1:0] shd_obs_q, shd_obs_d;
  logic [MAP_W-1:0] shd_obj_q, shd_obj_d;

  // Committed outputs
  logic [7:0]       d0_q, d0_d;
  logic [7:0]       d1_q, d1_d;
  logic [7:0]       d2_q, d2_d;
  logic [MAP_W-1:0] obs_q, obs_d;
  logic [MAP_W-1:0] obj_q, obj_d;
  logic             fv_q, fv_d;
  logic             fe_q, fe_d;

  // Bit offset of the current map byte; first byte received lands at the LSB
  logic [IDX_W-1:0] bit_idx_c;
  assign bit_idx_c = {cnt_q, 3'b000};

  logic rx_valid;
  logic [7:0] rx_data;
  assign rx_valid = bus.rx_valid;
  assign rx_data  = bus.rx_data;

  // Mid-frame inactivity abort
  logic abort_c;
`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Abort on the TIMEOUT_CYCLES-th consecutive idle cycle of a frame
  assign abort_c = (state_q != ST_IDLE) && !rx_valid && (tmo_q == TMO_LAST);

  // Cleared by every byte, held at zero in IDLE and after an abort
  always_comb begin
    tmo_d = tmo_q + TMO_W'(1);
    if ((state_q == ST_IDLE) || rx_valid || abort_c) begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign abort_c = 1'b0;
`endif

  // Next-state, shadow fill and commit logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shd0_d    = shd0_q;
    shd1_d    = shd1_q;
    shd2_d    = shd2_q;
    shd_obs_d = shd_obs_q;
    shd_obj_d = shd_obj_q;
    d0_d      = d0_q;
    d1_d      = d1_q;
    d2_d      = d2_q;
    obs_d     = obs_q;
    obj_d     = obj_q;
    fv_d      = 1'b0;
    fe_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Anything other than the start marker is dropped to resync
        if (rx_valid && (rx_data == START_BYTE)) begin
          state_d = ST_HEADER;
          cnt_d   = '0;
        end
      end

      ST_HEADER: begin
        if (rx_valid) begin
          case (cnt_q[1:0])
            2'd0:    shd0_d = rx_data;
            2'd1:    shd1_d = rx_data;
            default: shd2_d = rx_data;
          endcase
          if (cnt_q == LAST_HDR) begin
            state_d = ST_OBST;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_OBST: begin
        if (rx_valid) begin
          shd_obs_d[bit_idx_c +: 8] = rx_data;
          if (cnt_q == LAST_MAP) begin
            state_d = ST_OBJ;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_OBJ: begin
        if (rx_valid) begin
          shd_obj_d[bit_idx_c +: 8] = rx_data;
          if (cnt_q == LAST_MAP) begin
            state_d = ST_TAIL;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_TAIL: begin
        if (rx_valid) begin
          state_d = ST_IDLE;
          if (rx_data == END_BYTE) begin
            // Whole frame is good: publish every shadow register together
            d0_d  = shd0_q;
            d1_d  = shd1_q;
            d2_d  = shd2_q;
            obs_d = shd_obs_q;
            obj_d = shd_obj_q;
            fv_d  = 1'b1;
          end else begin
            fe_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort_c) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      fe_d    = 1'b1;
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shd0_q    <= '0;
      shd1_q    <= '0;
      shd2_q    <= '0;
      shd_obs_q <= '0;
      shd_obj_q <= '0;
      d0_q      <= '0;
      d1_q      <= '0;
      d2_q      <= '0;
      obs_q     <= '0;
      obj_q     <= '0;
      fv_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shd0_q    <= shd0_d;
      shd1_q    <= shd1_d;
      shd2_q    <= shd2_d;
      shd_obs_q <= shd_obs_d;
      shd_obj_q <= shd_obj_d;
      d0_q      <= d0_d;
      d1_q      <= d1_d;
      d2_q      <= d2_d;
      obs_q     <= obs_d;
      obj_q     <= obj_d;
      fv_q      <= fv_d;
      fe_q      <= fe_d;
    end
  end

  assign bus.D0             = d0_q;
  assign bus.D1             = d1_q;
  assign bus.D2             = d2_q;
  assign bus.map_obstacles  = obs_q;
  assign bus.map_objectives = obj_q;
  assign bus.frame_valid    = fv_q;
  assign bus.frame_error    = fe_q;
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.db_state       = state_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_serial_frame_receiver
//   Directed + randomized frames for serial_frame_receiver. Expected outputs
//   come from the frame contents the bench itself built: the last frame with
//   a correct end byte is what the outputs must show.
// ---------------------------------------------------------------------------
module tb_serial_frame_receiver;
  localparam int unsigned MAP_BYTES = 64;
  localparam int unsigned MAP_W     = MAP_BYTES * 8;
  localparam logic [7:0]  SB        = 8'hFF;
  localparam logic [7:0]  EB        = 8'hFE;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  serial_frame_receiver_if #(.MAP_BYTES(MAP_BYTES)) bus ();

  serial_frame_receiver #(
    .START_BYTE (SB),
    .END_BYTE   (EB),
    .MAP_BYTES  (MAP_BYTES)
`ifdef FRAME_TIMEOUT_EN
    , .TIMEOUT_CYCLES (100)
`endif
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int fv_seen  = 0;
  int fe_seen  = 0;

  // Frame under construction and expected committed outputs
  logic [7:0]       f_hdr [3];
  logic [7:0]       f_obs [MAP_BYTES];
  logic [7:0]       f_obj [MAP_BYTES];
  logic [7:0]       fq [$];
  logic [7:0]       exp_d [3];
  logic [MAP_W-1:0] exp_obs, exp_obj;

  task automatic chk(input string tag, input logic [MAP_W-1:0] obs,
                     input logic [MAP_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAP_W-1:0] pack_map(input logic [7:0] a [MAP_BYTES]);
    logic [MAP_W-1:0] m;
    m = '0;
    for (int k = 0; k < MAP_BYTES; k++) m[8*k +: 8] = a[k];
    return m;
  endfunction

  // Pulse bookkeeping and mutual exclusion of the two pulses
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.frame_valid === 1'b1) fv_seen++;
      if (bus.frame_error === 1'b1) fe_seen++;
      checks++;
      assert (!(bus.frame_valid === 1'b1 && bus.frame_error === 1'b1)) else begin
        failures++;
        $error("FAIL pulse_overlap observed=11 expected=not both");
      end
    end
  end

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic release_rx();
    @(negedge clock);
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 3; i++) f_hdr[i] = 8'($urandom);
    for (int k = 0; k < MAP_BYTES; k++) begin
      f_obs[k] = 8'($urandom);
      f_obj[k] = 8'($urandom);
    end
  endtask

  task automatic build_frame(input logic [7:0] tail);
    fq = {};
    fq.push_back(SB);
    for (int i = 0; i < 3; i++) fq.push_back(f_hdr[i]);
    for (int k = 0; k < MAP_BYTES; k++) fq.push_back(f_obs[k]);
    for (int k = 0; k < MAP_BYTES; k++) fq.push_back(f_obj[k]);
    fq.push_back(tail);
  endtask

  // Send bytes [lo, hi) of the current frame, optionally with random idle gaps
  task automatic send_range(input int lo, input int hi, input bit gap);
    for (int i = lo; i < hi; i++) begin
      if (gap && i > lo && $urandom_range(0, 7) == 0) begin
        release_rx();
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      send_byte(fq[i]);
    end
  endtask

  task automatic send_frame(input logic [7:0] tail, input bit gap, input bit fin);
    build_frame(tail);
    send_range(0, fq.size(), gap);
    if (fin) release_rx();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".D0"}, bus.D0, exp_d[0]);
    chk({tag, ".D1"}, bus.D1, exp_d[1]);
    chk({tag, ".D2"}, bus.D2, exp_d[2]);
    chk({tag, ".obs"}, bus.map_obstacles, exp_obs);
    chk({tag, ".obj"}, bus.map_objectives, exp_obj);
  endtask

  // Called on the negedge right after the tail byte was sampled
  task automatic check_commit(input string tag, input bit good);
    chk({tag, ".fv"}, bus.frame_valid, good);
    chk({tag, ".fe"}, bus.frame_error, !good);
    chk({tag, ".busy"}, bus.busy, 1'b0);
    if (good) begin
      for (int i = 0; i < 3; i++) exp_d[i] = f_hdr[i];
      exp_obs = pack_map(f_obs);
      exp_obj = pack_map(f_obj);
    end
    @(negedge clock);
    chk({tag, ".fv_end"}, bus.frame_valid, 1'b0);
    chk({tag, ".fe_end"}, bus.frame_error, 1'b0);
    check_outputs(tag);
  endtask

  initial begin
    int fe_before, fv_before;
    bit good, gap;
    logic [7:0] tail;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    for (int i = 0; i < 3; i++) exp_d[i] = 8'h00;
    exp_obs = '0;
    exp_obj = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check_outputs("reset");
    chk("reset.fv", bus.frame_valid, 1'b0);
    chk("reset.fe", bus.frame_error, 1'b0);
    chk("reset.busy", bus.busy, 1'b0);
    chk("reset.state", bus.db_state, 3'd0);
    reset_n = 1'b1;

    // T1: ramp frame, stepping through every section
    f_hdr[0] = 8'h01; f_hdr[1] = 8'h02; f_hdr[2] = 8'h03;
    for (int k = 0; k < MAP_BYTES; k++) begin
      f_obs[k] = 8'(k);
      f_obj[k] = 8'(8'h80 + k);
    end
    build_frame(EB);
    send_range(0, 1, 0);     release_rx();
    chk("t1.st_hdr", bus.db_state, 3'd1);
    chk("t1.busy", bus.busy, 1'b1);
    send_range(1, 4, 0);     release_rx();
    chk("t1.st_obst", bus.db_state, 3'd2);
    send_range(4, 68, 0);    release_rx();
    chk("t1.st_obj", bus.db_state, 3'd3);
    send_range(68, 132, 0);  release_rx();
    chk("t1.st_tail", bus.db_state, 3'd4);
    chk("t1.no_early", bus.D0, 8'h00);
    send_range(132, 133, 0); release_rx();
    check_commit("t1", 1'b1);
    chk("t1.obs_lo", bus.map_obstacles[7:0], 8'h00);
    chk("t1.obs_hi", bus.map_obstacles[511:504], 8'h3F);
    chk("t1.obj_lo", bus.map_objectives[7:0], 8'h80);
    chk("t1.obj_hi", bus.map_objectives[511:504], 8'hBF);

    // T2: good, bad tail (outputs hold), good again
    fill_random(); send_frame(EB, 0, 1);    check_commit("t2a", 1'b1);
    fill_random(); send_frame(8'h00, 0, 1); check_commit("t2bad", 1'b0);
    fill_random(); send_frame(EB, 0, 1);    check_commit("t2c", 1'b1);

    // T3: leading garbage, payload made of start-marker values
    send_byte(8'h12); send_byte(8'h34); release_rx();
    chk("t3.garbage_idle", bus.db_state, 3'd0);
    for (int i = 0; i < 3; i++) f_hdr[i] = 8'hFF;
    for (int k = 0; k < MAP_BYTES; k++) begin
      f_obs[k] = 8'hFF;
      f_obj[k] = 8'hFF;
    end
    send_frame(EB, 0, 1);
    check_commit("t3", 1'b1);

    // T4: reset after byte 70 of a frame
    fill_random();
    build_frame(EB);
    fe_before = fe_seen;
    send_range(0, 70, 0);
    @(negedge clock);
    reset_n      = 1'b0;
    bus.rx_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) exp_d[i] = 8'h00;
    exp_obs = '0;
    exp_obj = '0;
    check_outputs("t4.rst");
    chk("t4.rst_busy", bus.busy, 1'b0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    fill_random(); send_frame(EB, 0, 1); check_commit("t4", 1'b1);
    chk("t4.no_err", fe_seen, fe_before);

    // T5: two frames back to back, no gap
    fv_before = fv_seen;
    fill_random(); send_frame(EB, 0, 0);
    fill_random(); send_frame(EB, 0, 1);
    check_commit("t5", 1'b1);
    chk("t5.pulses", fv_seen - fv_before, 2);

    // Randomized frames: garbage, gaps, good or bad tails
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 254)));
      fill_random();
      good = ($urandom_range(0, 3) != 0);
      gap  = 1'($urandom);
      tail = good ? EB : 8'($urandom_range(0, 253));
      send_frame(tail, gap, 1);
      check_commit($sformatf("rnd%0d", it), good);
    end

`ifdef FRAME_TIMEOUT_EN
    // T6: stall after byte 10 -> abort on the 100th idle cycle
    fill_random();
    build_frame(EB);
    fe_before = fe_seen;
    send_range(0, 10, 0);
    release_rx();
    repeat (99) @(negedge clock);
    chk("t6.fe_before", bus.frame_error, 1'b0);
    chk("t6.busy_before", bus.busy, 1'b1);
    @(negedge clock);
    chk("t6.fe", bus.frame_error, 1'b1);
    chk("t6.busy", bus.busy, 1'b0);
    @(negedge clock);
    chk("t6.fe_end", bus.frame_error, 1'b0);
    chk("t6.one_err", fe_seen - fe_before, 1);
    check_outputs("t6");
`else
    // Long mid-frame stall is tolerated without a timeout
    fill_random();
    build_frame(EB);
    send_range(0, 10, 0);
    release_rx();
    repeat (300) @(negedge clock);
    chk("stall.state", bus.db_state, 3'd2);
    send_range(10, fq.size(), 0);
    release_rx();
    check_commit("stall", 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
